// File: rtl/mult_parity_responder.sv
// Responder for the req/ack/result_rdy multiply protocol with operand parity checking.
// Latency: ack 1 cycle after req is sampled, result_rdy LATENCY cycles after ack (1 cycle on parity error).
// Backpressure: none; one operation in flight, req is ignored until the FSM is back in IDLE.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   req                       level request, held by the tester until ack is seen
//   arg_a/arg_b (+_parity)    signed operands with their even-parity bits, sampled on the req edge
//   ack                       1-cycle pulse: operands captured
//   result, result_parity     signed 2*DATA_W product and its parity (0/0 on parity error)
//   result_rdy                1-cycle pulse: result, result_parity and arg_parity_error are valid
//   arg_parity_error          operand parity mismatch on arg_a and/or arg_b
module mult_parity_responder #(
    parameter int DATA_W  = 16,
    parameter int LATENCY = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic [DATA_W-1:0]     arg_a,
    input  logic                  arg_a_parity,
    input  logic [DATA_W-1:0]     arg_b,
    input  logic                  arg_b_parity,
    output logic                  ack,
    output logic [2*DATA_W-1:0]   result,
    output logic                  result_parity,
    output logic                  result_rdy,
    output logic                  arg_parity_error
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACK  = 2'd1,
        S_BUSY = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // BUSY is entered with LATENCY-1 and left when the count reaches 1, giving
    // LATENCY-1 BUSY cycles so that ACK + BUSY cycles add up to LATENCY.
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t                state;
    state_t                state_nxt;
    logic [3:0]            cnt;
    logic [3:0]            cnt_nxt;

    logic [DATA_W-1:0]     op_a;
    logic [DATA_W-1:0]     op_b;
    logic                  op_a_par;
    logic                  op_b_par;

    logic                  op_err;
    logic [2*DATA_W-1:0]   ext_a;
    logic [2*DATA_W-1:0]   ext_b;
    logic [2*DATA_W-1:0]   product;

    logic                  ack_nxt;
    logic                  rdy_nxt;
    logic [2*DATA_W-1:0]   result_nxt;
    logic                  result_parity_nxt;
    logic                  err_nxt;

    assign op_err = (op_a_par != ^op_a) | (op_b_par != ^op_b);

    // Sign-extend to full product width; the low 2*DATA_W bits of the
    // product of the extended operands are the exact signed product,
    // including (-2^(DATA_W-1))^2.
    assign ext_a   = {{DATA_W{op_a[DATA_W-1]}}, op_a};
    assign ext_b   = {{DATA_W{op_b[DATA_W-1]}}, op_b};
    assign product = ext_a * ext_b;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Operand capture: only on the IDLE edge that accepts req, so later
    // changes on the inputs cannot disturb the operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a     <= '0;
            op_b     <= '0;
            op_a_par <= 1'b0;
            op_b_par <= 1'b0;
        end else if (state == S_IDLE && req) begin
            op_a     <= arg_a;
            op_b     <= arg_b;
            op_a_par <= arg_a_parity;
            op_b_par <= arg_b_parity;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                if (req) state_nxt = S_ACK;
            end
            S_ACK: begin
                if (op_err || LATENCY == 1) begin
                    state_nxt = S_DONE;
                end else begin
                    state_nxt = S_BUSY;
                    cnt_nxt   = CNT_INIT;
                end
            end
            S_BUSY: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt <= 4'd1) state_nxt = S_DONE;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    // Output logic: next values for the registered outputs. ack and
    // result_rdy are high exactly while the FSM sits in ACK and DONE.
    always_comb begin
        ack_nxt           = (state == S_IDLE) && req;
        rdy_nxt           = (state_nxt == S_DONE);
        result_nxt        = result;
        result_parity_nxt = result_parity;
        err_nxt           = arg_parity_error;
        if (rdy_nxt) begin
            result_nxt        = op_err ? '0 : product;
            result_parity_nxt = ^result_nxt;
            err_nxt           = op_err;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack              <= 1'b0;
            result_rdy       <= 1'b0;
            result           <= '0;
            result_parity    <= 1'b0;
            arg_parity_error <= 1'b0;
        end else begin
            ack              <= ack_nxt;
            result_rdy       <= rdy_nxt;
            result           <= result_nxt;
            result_parity    <= result_parity_nxt;
            arg_parity_error <= err_nxt;
        end
    end

endmodule

// File: tb/tb_mult_parity_responder.sv
module tb_mult_parity_responder;

    localparam int DW  = 16;
    localparam int LAT = 3;

    logic          clk;
    logic          rst;
    logic          req;
    logic [DW-1:0] arg_a;
    logic          arg_a_parity;
    logic [DW-1:0] arg_b;
    logic          arg_b_parity;
    logic          ack;
    logic [2*DW-1:0] result;
    logic          result_parity;
    logic          result_rdy;
    logic          arg_parity_error;

    int checks = 0;
    int errors = 0;

    // Scoreboard entries: {arg_parity_error, result_parity, result}
    logic [33:0] exp_q[$];

    mult_parity_responder #(.DATA_W(DW), .LATENCY(LAT)) dut (
        .clk              (clk),
        .rst              (rst),
        .req              (req),
        .arg_a            (arg_a),
        .arg_a_parity     (arg_a_parity),
        .arg_b            (arg_b),
        .arg_b_parity     (arg_b_parity),
        .ack              (ack),
        .result           (result),
        .result_parity    (result_parity),
        .result_rdy       (result_rdy),
        .arg_parity_error (arg_parity_error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drives one operation, pushes its model result, waits (bounded) for ack
    // and result_rdy and returns what the DUT produced. lat counts cycles
    // from the ack cycle to the result_rdy cycle.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                         input logic ap, input logic bp, input bit scramble,
                         output bit got_ack, output bit got_rdy, output int lat,
                         output logic [31:0] r, output logic rp, output logic re);
        int ia;
        int ib;
        logic [31:0] p;
        logic e;
        ia = int'($signed(a));
        ib = int'($signed(b));
        p  = ia * ib;
        e  = (ap != ^a) || (bp != ^b);
        if (e) p = 32'd0;
        exp_q.push_back({e, ^p, p});
        @(negedge clk);
        arg_a = a; arg_b = b; arg_a_parity = ap; arg_b_parity = bp;
        req = 1'b1;
        got_ack = 1'b0;
        for (int i = 0; i < 20 && !got_ack; i++) begin
            @(negedge clk);
            if (ack) got_ack = 1'b1;
        end
        req = 1'b0;
        got_rdy = 1'b0;
        lat = 0;
        while (!got_rdy && lat < 40) begin
            @(negedge clk);
            lat++;
            if (scramble) begin
                arg_a = 16'($urandom); arg_b = 16'($urandom);
                arg_a_parity = 1'($urandom); arg_b_parity = 1'($urandom);
            end
            if (result_rdy) got_rdy = 1'b1;
        end
        r = result; rp = result_parity; re = arg_parity_error;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 1'b0;
        arg_a = '0; arg_b = '0; arg_a_parity = 1'b0; arg_b_parity = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({ack, result_rdy, result_parity, arg_parity_error} !== 4'b0000 || result !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs: ack=%b rdy=%b res=%h par=%b err=%b, required all 0",
                     ack, result_rdy, result, result_parity, arg_parity_error);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (ack !== 1'b0 || result_rdy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: ack=%b rdy=%b, required 0 0", ack, result_rdy);
        end
    endtask

    task automatic test_directed();
        logic [15:0] ta[5] = '{16'h7FFF, 16'h8000, 16'h0001, 16'h8000, 16'h0004};
        logic [15:0] tb[5] = '{16'h7FFF, 16'hFFFF, 16'h0005, 16'h8000, 16'h0007};
        logic        bada[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic        badb[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [31:0] kres[5] = '{32'h3FFF0001, 32'h00008000, 32'h0, 32'h40000000, 32'h0};
        logic        kpar[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic        kerr[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        bit ga, gr; int lat; logic [31:0] r; logic rp, re; logic [33:0] ex;
        for (int k = 0; k < 5; k++) begin
            do_op(ta[k], tb[k], (^ta[k]) ^ bada[k], (^tb[k]) ^ badb[k], 1'b0, ga, gr, lat, r, rp, re);
            ex = exp_q.pop_front();
            checks++;
            if (!ga || !gr) begin
                errors++;
                $display("FAIL directed%0d_handshake: ack=%b rdy=%b, required 1 1", k, ga, gr);
            end
            checks++;
            if (r !== kres[k] || rp !== kpar[k] || re !== kerr[k] || {re, rp, r} !== ex) begin
                errors++;
                $display("FAIL directed%0d_result: got res=%h par=%b err=%b, required res=%h par=%b err=%b",
                         k, r, rp, re, kres[k], kpar[k], kerr[k]);
            end
            checks++;
            if (lat != (kerr[k] ? 1 : LAT)) begin
                errors++;
                $display("FAIL directed%0d_latency: got %0d, required %0d", k, lat, kerr[k] ? 1 : LAT);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] ba[3] = '{16'h0000, 16'hFFFF, 16'h0003};
        logic [15:0] bb[3] = '{16'h1234, 16'h0002, 16'h0003};
        int nack, nrdy, cyc, last_ack, extra;
        logic [33:0] ex;
        exp_q.push_back({1'b0, 1'b0, 32'h00000000});
        exp_q.push_back({1'b0, 1'b1, 32'hFFFFFFFE});
        exp_q.push_back({1'b0, 1'b0, 32'h00000009});
        @(negedge clk);
        arg_a = ba[0]; arg_b = bb[0]; arg_a_parity = ^ba[0]; arg_b_parity = ^bb[0];
        req = 1'b1;
        nack = 0; nrdy = 0; cyc = 0; last_ack = 0;
        while (nrdy < 3 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (ack) begin
                if (nack > 0) begin
                    checks++;
                    if (cyc - last_ack != LAT + 2) begin
                        errors++;
                        $display("FAIL b2b_ack_spacing: got %0d, required %0d", cyc - last_ack, LAT + 2);
                    end
                end
                last_ack = cyc;
                nack++;
                if (nack < 3) begin
                    arg_a = ba[nack]; arg_b = bb[nack];
                    arg_a_parity = ^ba[nack]; arg_b_parity = ^bb[nack];
                end else begin
                    req = 1'b0;
                end
            end
            if (result_rdy) begin
                ex = exp_q.pop_front();
                checks++;
                if ({arg_parity_error, result_parity, result} !== ex) begin
                    errors++;
                    $display("FAIL b2b_result%0d: got err=%b par=%b res=%h, required err=%b par=%b res=%h",
                             nrdy, arg_parity_error, result_parity, result, ex[33], ex[32], ex[31:0]);
                end
                nrdy++;
            end
        end
        req = 1'b0;
        extra = 0;
        repeat (LAT + 4) begin
            @(negedge clk);
            if (ack || result_rdy) extra++;
        end
        checks++;
        if (nack != 3 || nrdy != 3 || extra != 0) begin
            errors++;
            $display("FAIL b2b_counts: acks=%0d rdys=%0d extra=%0d, required 3 3 0", nack, nrdy, extra);
        end
    endtask

    task automatic test_reset_mid_busy();
        bit seen_ack, ga, gr; int lat, spur; logic [31:0] r; logic rp, re; logic [33:0] ex;
        @(negedge clk);
        arg_a = 16'h0010; arg_b = 16'h0011; arg_a_parity = ^16'h0010; arg_b_parity = ^16'h0011;
        req = 1'b1;
        seen_ack = 1'b0;
        for (int i = 0; i < 20 && !seen_ack; i++) begin
            @(negedge clk);
            if (ack) seen_ack = 1'b1;
        end
        req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (!seen_ack || {ack, result_rdy, result_parity, arg_parity_error} !== 4'b0000 || result !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid_busy_outputs: ack_seen=%b ack=%b rdy=%b res=%h par=%b err=%b, required ack_seen=1 rest 0",
                     seen_ack, ack, result_rdy, result, result_parity, arg_parity_error);
        end
        @(negedge clk);
        rst = 1'b0;
        spur = 0;
        repeat (LAT + 5) begin
            @(negedge clk);
            if (ack || result_rdy) spur++;
        end
        checks++;
        if (spur != 0) begin
            errors++;
            $display("FAIL reset_mid_busy_no_rdy: got %0d pulses, required 0", spur);
        end
        do_op(16'h0002, 16'h0003, ^16'h0002, ^16'h0003, 1'b0, ga, gr, lat, r, rp, re);
        ex = exp_q.pop_front();
        checks++;
        if (!ga || !gr || r !== 32'h6 || rp !== 1'b0 || re !== 1'b0 || {re, rp, r} !== ex || lat != LAT) begin
            errors++;
            $display("FAIL after_reset_op: ack=%b rdy=%b lat=%0d res=%h par=%b err=%b, required 1 1 %0d 00000006 0 0",
                     ga, gr, lat, r, rp, re, LAT);
        end
    endtask

    task automatic test_random();
        logic [15:0] corner[5] = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF};
        logic [15:0] a, b; logic ap, bp;
        bit ga, gr; int lat; logic [31:0] r; logic rp, re; logic [33:0] ex;
        int bad_res, bad_par, bad_err, bad_hs;
        bad_res = 0; bad_par = 0; bad_err = 0; bad_hs = 0;
        for (int n = 0; n < 1000; n++) begin
            a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : 16'($urandom);
            b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : 16'($urandom);
            ap = (^a) ^ ($urandom_range(0, 9) == 0);
            bp = (^b) ^ ($urandom_range(0, 9) == 0);
            do_op(a, b, ap, bp, 1'($urandom), ga, gr, lat, r, rp, re);
            ex = exp_q.pop_front();
            checks++;
            if (!ga || !gr || lat != (ex[33] ? 1 : LAT)) begin
                errors++; bad_hs++;
                if (bad_hs <= 5)
                    $display("FAIL rand%0d_handshake: ack=%b rdy=%b lat=%0d, required 1 1 %0d",
                             n, ga, gr, lat, ex[33] ? 1 : LAT);
            end
            checks++;
            if (r !== ex[31:0]) begin
                errors++; bad_res++;
                if (bad_res <= 5)
                    $display("FAIL rand%0d_result: a=%h b=%h got %h, required %h", n, a, b, r, ex[31:0]);
            end
            checks++;
            if (rp !== ex[32]) begin
                errors++; bad_par++;
                if (bad_par <= 5)
                    $display("FAIL rand%0d_result_parity: got %b, required %b", n, rp, ex[32]);
            end
            checks++;
            if (re !== ex[33]) begin
                errors++; bad_err++;
                if (bad_err <= 5)
                    $display("FAIL rand%0d_arg_parity_error: got %b, required %b", n, re, ex[33]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid_busy();
        test_random();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
